nios_system_led_fader: RTL and testbench

//  Downstream stage of the red-LED PIO. Consumes the 18-bit LED register value
//  (out_port) and drives the board LEDs through per-channel PWM.
//  A bit going 1 fades its LED up to a global brightness; a bit going 0 fades it down to off.

---
 rtl/nios_system_led_fader.sv | 143 ++++++++++++++
 tb/tb_nios_system_led_fader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_led_fader.sv
// -----------------------------------------------------------------------------
// nios_system_led_fader
//
// PWM fader for the red-LED PIO. Each bit of the registered LED request
// fades its channel up to the global brightness when set, and down to zero
// when clear. One fade step of STEP is applied per tick, and a tick happens
// once every PRESCALE clocks. Each channel level is compared against a shared
// free-running 8-bit PWM counter to drive the pin.
//
// Optional build macro:
//   LED_GAMMA_EN  duty = (level*level) >> 8 (square-law perceptual curve).
//                 When it is undefined, duty = level and no multiplier is
//                 built.
//
// Parameters:
//   WIDTH      number of LED channels
//   PRESCALE   clk cycles per fade tick (>= 1)
//   STEP       level change per fade tick (1..255)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset (release synchronised upstream)
//   led_in      LED request bits from the PIO out_port, synchronous to clk
//   brightness  target level for channels that are requested on
//   led_out     registered PWM drive to the LED pins
//   busy        registered; 1 while any channel level differs from its target
// -----------------------------------------------------------------------------
module nios_system_led_fader #(
   parameter int unsigned WIDTH    = 18,
   parameter int unsigned PRESCALE = 195,
   parameter int unsigned STEP     = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] led_in,
   input  logic [7:0]       brightness,
   output logic [WIDTH-1:0] led_out,
   output logic             busy
);

   // Prescaler counter width. A one-bit counter that stays at 0 covers
   // PRESCALE == 1, where every cycle is a tick.
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PrescLast = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PrescOne  = PW'(1);
   localparam logic [8:0]    Step9     = 9'(STEP);
   localparam logic [9:0]    Step10    = 10'(STEP);

   if (PRESCALE < 1) begin : gen_bad_prescale
      $error("PRESCALE must be at least 1");
   end
   if (STEP < 1 || STEP > 255) begin : gen_bad_step
      $error("STEP must be in 1..255");
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0]      led_q;
   logic [PW-1:0]         presc_q;
   logic [PW-1:0]         presc_d;
   logic                  tick;
   logic [7:0]            pwm_cnt_q;
   logic [WIDTH-1:0][7:0] level_q;
   logic [WIDTH-1:0][7:0] level_d;

   // Per-channel combinational results
   logic [WIDTH-1:0]      pwm_on;
   logic [WIDTH-1:0]      off_target;

   // ---------------------------------------------------------------------------
   // Fade tick generation
   // ---------------------------------------------------------------------------
   assign tick    = (presc_q == PrescLast);
   assign presc_d = tick ? '0 : presc_q + PrescOne;

   // ---------------------------------------------------------------------------
   // Per-channel fade and PWM compare
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < WIDTH; g++) begin : gen_ch
      logic [7:0]        target;
      logic [8:0]        up_sum;
      logic signed [9:0] dn_diff;
      logic [7:0]        next_up;
      logic [7:0]        next_dn;
      logic [7:0]        duty;

      // Decisions use the registered request. A tick that coincides with a
      // led_in change therefore still sees the old request.
      assign target = led_q[g] ? brightness : 8'd0;

      // Up-step computed 9 bits wide so level+STEP cannot wrap past 255.
      assign up_sum  = {1'b0, level_q[g]} + Step9;
      assign next_up = (up_sum > {1'b0, target}) ? target : up_sum[7:0];

      // Down-step computed signed so level-STEP cannot wrap below 0.
      assign dn_diff = $signed({2'b00, level_q[g]}) - $signed(Step10);
      assign next_dn = (dn_diff < $signed({2'b00, target})) ? target : dn_diff[7:0];

      // A request reversal mid-ramp simply changes direction from the
      // current level. There is no restart.
      assign level_d[g] = !tick                 ? level_q[g] :
                          (level_q[g] < target) ? next_up    :
                          (level_q[g] > target) ? next_dn    :
                                                  level_q[g];

`ifdef LED_GAMMA_EN
      // Square-law curve: duty = level^2 / 256. Combinational from the level
      // register into the compare register, so latency is unchanged.
      logic [15:0] level_sq;
      assign level_sq = {8'd0, level_q[g]} * {8'd0, level_q[g]};
      assign duty     = level_sq[15:8];
`else
      assign duty = level_q[g];
`endif

      // Level 0 never lights, and level 255 lights 255 of 256 clocks.
      assign pwm_on[g]     = (pwm_cnt_q < duty);
      assign off_target[g] = (level_q[g] != target);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_q     <= '0;
         presc_q   <= '0;
         pwm_cnt_q <= 8'd0;
         level_q   <= '0;
         led_out   <= '0;
         busy      <= 1'b0;
      end else begin
         led_q     <= led_in;
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
         level_q   <= level_d;
         led_out   <= pwm_on;
         busy      <= |off_target;
      end
   end

endmodule

// File: tb/tb_nios_system_led_fader.sv
// -----------------------------------------------------------------------------
// tb_nios_system_led_fader
//
// Scoreboard bench for nios_system_led_fader (WIDTH=18, PRESCALE=4, STEP=16).
// The stimulus process pushes expected observations into a queue. A monitor
// process pops each one and watches the DUT until that observation appears:
// a level step, a busy or led_out value, or a PWM on-time over 256 clocks.
// -----------------------------------------------------------------------------
module tb_nios_system_led_fader;

   localparam int unsigned WIDTH    = 18;
   localparam int unsigned PRESCALE = 4;
   localparam int unsigned STEP     = 16;

   localparam int KLevel = 0;  // wait for level[ch] to move off prev, expect exp
   localparam int KBusy  = 1;  // sample busy now
   localparam int KOut   = 2;  // sample led_out now
   localparam int KDuty  = 3;  // count led_out[ch] high over 256 clocks
   localparam int KQuiet = 4;  // 1024 clocks of led_out==0 and busy==0

`ifdef LED_GAMMA_EN
   localparam int Duty255 = 254;
   localparam int Duty128 = 64;
   localparam int Duty64  = 16;
`else
   localparam int Duty255 = 255;
   localparam int Duty128 = 128;
   localparam int Duty64  = 64;
`endif

   typedef struct {
      int    kind;
      int    ch;
      int    prev;
      int    exp;
      string name;
   } item_t;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] led_in;
   logic [7:0]       brightness;
   logic [WIDTH-1:0] led_out;
   logic             busy;

   item_t sb[$];
   bit    mon_busy = 0;
   int    n_checks = 0;
   int    n_pass   = 0;

   nios_system_led_fader #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE),
      .STEP     (STEP)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .led_in     (led_in),
      .brightness (brightness),
      .led_out    (led_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int get_level(int ch);
      return int'(dut.level_q[ch]);
   endfunction

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push(int kind, int ch, int prev, int exp, string name);
      item_t it;
      it.kind = kind;
      it.ch   = ch;
      it.prev = prev;
      it.exp  = exp;
      it.name = name;
      sb.push_back(it);
   endtask

   // Expected ramp from 'from' to 'to' in STEP increments, clamped at 'to'.
   task automatic push_ramp(int ch, int from, int to, string name);
      int v = from;
      int nv;
      while (v != to) begin
         if (to > v) nv = (v + STEP > to) ? to : v + STEP;
         else        nv = (v - STEP < to) ? to : v - STEP;
         push(KLevel, ch, v, nv, $sformatf("%s ch%0d %0d->%0d", name, ch, v, nv));
         v = nv;
      end
   endtask

   task automatic wait_drain(string name);
      for (int i = 0; i < 5000; i++) begin
         if (sb.size() == 0 && !mon_busy) return;
         @(posedge clk);
      end
      $display("FAIL %s: scoreboard still holds %0d items, expected 0", name, sb.size());
      $fatal(1, "scoreboard stalled");
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n    = 1'b0;
      led_in     = '0;
      brightness = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: pops expectations and compares against what the DUT presents.
   // ---------------------------------------------------------------------------
   initial begin
      item_t it;
      int    cnt;
      int    cnt2;
      bit    seen;
      forever begin
         wait (sb.size() > 0);
         mon_busy = 1;
         it = sb.pop_front();
         case (it.kind)
            KLevel: begin
               seen = 0;
               for (int i = 0; i < 40 && !seen; i++) begin
                  @(negedge clk);
                  if (get_level(it.ch) != it.prev) seen = 1;
               end
               check(it.name, get_level(it.ch), it.exp);
            end
            KBusy: begin
               @(negedge clk);
               check(it.name, int'(busy), it.exp);
            end
            KOut: begin
               @(negedge clk);
               check(it.name, int'(led_out), it.exp);
            end
            KDuty: begin
               cnt = 0;
               for (int i = 0; i < 256; i++) begin
                  @(negedge clk);
                  if (led_out[it.ch]) cnt++;
               end
               check(it.name, cnt, it.exp);
            end
            KQuiet: begin
               cnt  = 0;
               cnt2 = 0;
               for (int i = 0; i < 1024; i++) begin
                  @(negedge clk);
                  if (led_out == '0) cnt++;
                  if (!busy) cnt2++;
               end
               check({it.name, " led_out zero clocks"}, cnt, it.exp);
               check({it.name, " busy low clocks"}, cnt2, it.exp);
            end
            default: check("bad item kind", it.kind, 0);
         endcase
         mon_busy = 0;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      reset_n    = 1'b0;
      led_in     = '0;
      brightness = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state
      push(KOut,  0, 0, 0, "reset led_out");
      push(KBusy, 0, 0, 0, "reset busy");
      wait_drain("reset");

      // 1: full-brightness ramp on bit 0
      do_reset();
      brightness = 8'd255;
      led_in     = 18'h00001;
      push_ramp(0, 0, 16, "t1 ramp");
      push(KBusy, 0, 0, 1, "t1 busy during ramp");
      push_ramp(0, 16, 255, "t1 ramp");
      push(KBusy, 0, 0, 0, "t1 busy after ramp");
      push(KDuty, 0, 0, Duty255, "t1 duty at 255");
      wait_drain("t1");

      // 2: requests on but brightness 0
      do_reset();
      brightness = 8'd0;
      led_in     = 18'h3FFFF;
      push(KQuiet, 0, 0, 1024, "t2");
      wait_drain("t2");

      // 3: up to 128 on bit 5, then release
      do_reset();
      brightness = 8'd128;
      led_in     = 18'h00020;
      push_ramp(5, 0, 128, "t3 up");
      wait_drain("t3 up");
      led_in = 18'h00000;
      push_ramp(5, 128, 0, "t3 down");
      push(KBusy, 0, 0, 0, "t3 busy at 0");
      push(KOut,  0, 0, 0, "t3 led_out off");
      wait_drain("t3 down");

      // 4: bit 17 at 255, then re-target to 64
      do_reset();
      brightness = 8'd255;
      led_in     = 18'h20000;
      push_ramp(17, 0, 255, "t4 up");
      wait_drain("t4 up");
      brightness = 8'd64;
      push_ramp(17, 255, 64, "t4 retarget");
      push(KBusy, 0, 0, 0, "t4 busy settled");
      push(KDuty, 17, 0, Duty64, "t4 duty at 64");
      wait_drain("t4");

      // 5: reset pulse mid-ramp with all bits on
      do_reset();
      brightness = 8'd255;
      led_in     = 18'h3FFFF;
      push_ramp(0, 0, 48, "t5 pre");
      wait_drain("t5 pre");
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      push(KOut,  0, 0, 0, "t5 led_out in reset");
      push(KBusy, 0, 0, 0, "t5 busy in reset");
      wait_drain("t5 in reset");
      @(posedge clk);
      #1;
      push(KLevel, 0,  0, 16, "t5 restart ch0");
      push(KLevel, 17, 0, 16, "t5 restart ch17");
      reset_n = 1'b1;
      wait_drain("t5 restart");

      // 6: hold level 128 on bit 0
      do_reset();
      brightness = 8'd128;
      led_in     = 18'h00001;
      push_ramp(0, 0, 128, "t6 up");
      push(KDuty, 0, 0, Duty128, "t6 duty at 128");
      wait_drain("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
